// File: rtl/pfsplit.sv
// Instruction-word splitter between the single-word prefetch and the decoder.
// Holds one word and issues it whole, or as two compressed halves when bit 31 is set.
module pfsplit #(
  parameter int          ADDRESS_WIDTH = 30,
  parameter logic [14:0] NOOP_HALF     = 15'h7c00
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_new_pc,
  input  logic                     i_clear_cache,
  input  logic                     i_new_half,
  input  logic                     i_pf_valid,
  input  logic [31:0]              i_pf_insn,
  input  logic [ADDRESS_WIDTH-1:0] i_pf_pc,
  input  logic                     i_pf_illegal,
  output logic                     o_pf_ready,
  output logic                     o_valid,
  output logic [31:0]              o_insn,
  output logic [ADDRESS_WIDTH-1:0] o_pc,
  output logic                     o_half,
  output logic                     o_compressed,
  output logic                     o_illegal,
  input  logic                     i_ready
);

  logic                     valid_q, valid_d;
  logic [31:0]              word_q, word_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     illegal_q, illegal_d;
  logic                     misalign_q, misalign_d;
  logic                     phase_q, phase_d;
  logic                     skip_first_q, skip_first_d;

  logic flush;
  logic last;
  logic load;

  assign flush      = i_rst || i_new_pc || i_clear_cache;
  assign last       = !word_q[31] || illegal_q || phase_q || (word_q[14:0] == NOOP_HALF);
  assign o_pf_ready = !valid_q || (i_ready && last);
  assign load       = i_pf_valid && o_pf_ready;

  // Flush beats any load or handshake; otherwise a load replaces the held word
  always_comb begin
    valid_d      = valid_q;
    word_d       = word_q;
    pc_d         = pc_q;
    illegal_d    = illegal_q;
    misalign_d   = misalign_q;
    phase_d      = phase_q;
    skip_first_d = skip_first_q;
    if (flush) begin
      valid_d = 1'b0;
      phase_d = 1'b0;
      if (i_new_pc) begin
        skip_first_d = i_new_half;
      end
    end else if (load) begin
      valid_d      = 1'b1;
      word_d       = i_pf_insn;
      pc_d         = i_pf_pc;
      misalign_d   = skip_first_q && !i_pf_insn[31] && !i_pf_illegal;
      illegal_d    = i_pf_illegal || (skip_first_q && !i_pf_insn[31]);
      phase_d      = skip_first_q && i_pf_insn[31] && !i_pf_illegal;
      skip_first_d = 1'b0;
    end else if (valid_q && i_ready) begin
      if (last) begin
        valid_d = 1'b0;
      end else begin
        phase_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q      <= 1'b0;
      word_q       <= '0;
      pc_q         <= '0;
      illegal_q    <= 1'b0;
      misalign_q   <= 1'b0;
      phase_q      <= 1'b0;
      skip_first_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      word_q       <= word_d;
      pc_q         <= pc_d;
      illegal_q    <= illegal_d;
      misalign_q   <= misalign_d;
      phase_q      <= phase_d;
      skip_first_q <= skip_first_d;
    end
  end

  // Illegal items are never split; a misaligned target reports as a second half
  always_comb begin
    o_valid      = valid_q;
    o_pc         = pc_q;
    o_illegal    = illegal_q;
    o_half       = phase_q || misalign_q;
    o_compressed = word_q[31] && !illegal_q;
    o_insn       = word_q;
    if (word_q[31] && !illegal_q) begin
      if (phase_q) begin
        o_insn = {16'h0, 1'b1, word_q[14:0]};
      end else begin
        o_insn = {16'h0, word_q[31:16]};
      end
    end
  end

endmodule
